// File: rtl/pixel_filter_pkg.sv
// Shared types and helpers for the per-frame pixel filter scheduler.
package pixel_filter_pkg;

    localparam int PIX_W = 8;
    localparam int BPM_W = 8;

    // Active pixel source feeding the output register.
    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_THRESH = 2'd1,
        SEL_BRIGHT = 2'd2
    } sel_t;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Map a BPM value onto a filter band (unsigned compares).
    function automatic sel_t sel_decode(
        input logic [BPM_W-1:0] bpm,
        input logic [BPM_W-1:0] bright_bpm,
        input logic [BPM_W-1:0] thresh_bpm
    );
        sel_t s;
        if (bpm >= bright_bpm) begin
            s = SEL_BRIGHT;
        end else if (bpm >= thresh_bpm) begin
            s = SEL_THRESH;
        end else begin
            s = SEL_BYPASS;
        end
        return s;
    endfunction

endpackage

// File: rtl/pixel_filter_scheduler_pixel_out_reg.sv
// One-entry valid/ready output register. The caller only asserts load
// while free is high, so a held pixel is never overwritten.
module pixel_out_reg
    import pixel_filter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PIX_W-1:0] data_in,
    input  logic             out_ready,
    output logic [PIX_W-1:0] data_out,
    output logic             valid_out,
    output logic             free
);

    logic [PIX_W-1:0] data_d;
    logic [PIX_W-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // Register can take a new pixel when empty or being drained this cycle.
    always_comb begin
        free = !valid_q || out_ready;
    end

    // Load has priority; otherwise a downstream handshake empties the entry.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = data_in;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage; reset empties the register and clears the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {PIX_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/pixel_filter_scheduler.sv
// Frame scheduler for the threshold/brightness filter bank: latches BPM
// updates, applies them only at frame start, picks one pixel stream by
// BPM band and merges it into a registered valid/ready output.
module pixel_filter_scheduler
    import pixel_filter_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19,
    parameter int BRIGHT_BPM   = 120,
    parameter int THRESH_BPM   = 80,
    parameter int DEFAULT_BPM  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BPM_W-1:0] bpm_in,
    input  logic             bpm_valid,
    input  logic             enable_in,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             valid_in,
    output logic             in_ready,
    output logic [BPM_W-1:0] BPM_estimate,
    output logic             filter_enable,
    output logic             filt_ready,
    input  logic [PIX_W-1:0] pix_thresh,
    input  logic             valid_thresh,
    input  logic [PIX_W-1:0] pix_bright,
    input  logic             valid_bright,
    output logic [PIX_W-1:0] pix_out,
    output logic             valid_out,
    input  logic             output_ready,
    output logic [1:0]       sel,
    output logic             frame_start,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [BPM_W-1:0] BPM_DEFAULT = BPM_W'(DEFAULT_BPM);
    localparam logic [BPM_W-1:0] BPM_BRIGHT  = BPM_W'(BRIGHT_BPM);
    localparam logic [BPM_W-1:0] BPM_THRESH  = BPM_W'(THRESH_BPM);

    state_t           state_d;
    state_t           state_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    logic [BPM_W-1:0] bpm_active_d;
    logic [BPM_W-1:0] bpm_active_q;
    logic [BPM_W-1:0] bpm_pending_d;
    logic [BPM_W-1:0] bpm_pending_q;
    sel_t             sel_d;
    sel_t             sel_q;

    logic             in_stream_s;
    logic             filt_sel_s;
    logic             free_s;
    logic             hs_s;
    logic             last_hs_s;
    logic             src_valid_s;
    logic [PIX_W-1:0] src_pix_s;
    logic             load_s;

    // Handshake and frame-boundary decode. The boundary handshake blocks
    // new loads so the next frame starts with an empty register after LOAD.
    always_comb begin
        in_stream_s = (state_q == STREAM);
        filt_sel_s  = (sel_q != SEL_BYPASS);
        hs_s        = valid_out && output_ready;
        last_hs_s   = in_stream_s && hs_s && (count_q == LAST_CNT);
    end

    // Source mux: only the selected stream can reach the output register.
    always_comb begin
        src_valid_s = 1'b0;
        src_pix_s   = {PIX_W{1'b0}};
        case (sel_q)
            SEL_BYPASS: begin
                src_valid_s = valid_in;
                src_pix_s   = pix_in;
            end
            SEL_THRESH: begin
                src_valid_s = valid_thresh;
                src_pix_s   = pix_thresh;
            end
            SEL_BRIGHT: begin
                src_valid_s = valid_bright;
                src_pix_s   = pix_bright;
            end
            default: begin
                src_valid_s = 1'b0;
                src_pix_s   = {PIX_W{1'b0}};
            end
        endcase
    end

    // Ready/enable fan-out to the pixel source and filter bank.
    always_comb begin
        load_s        = in_stream_s && free_s && src_valid_s && !last_hs_s;
        in_ready      = in_stream_s && free_s && !filt_sel_s && !last_hs_s;
        filt_ready    = in_stream_s && free_s && filt_sel_s && !last_hs_s;
        filter_enable = in_stream_s && filt_sel_s;
        frame_start   = (state_q == LOAD);
        frame_done    = last_hs_s;
        BPM_estimate  = bpm_active_q;
        sel           = sel_q;
    end

    // Pending BPM tracks the latest strobe in every state.
    always_comb begin
        if (bpm_valid) begin
            bpm_pending_d = bpm_in;
        end else begin
            bpm_pending_d = bpm_pending_q;
        end
    end

    // Frame FSM: LOAD applies the pending BPM and band, STREAM counts
    // output handshakes until the frame is complete.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        bpm_active_d = bpm_active_q;
        sel_d        = sel_q;
        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                bpm_active_d = bpm_pending_q;
                sel_d        = sel_decode(bpm_pending_q, BPM_BRIGHT, BPM_THRESH);
                count_d      = {CNT_W{1'b0}};
                state_d      = STREAM;
            end
            STREAM: begin
                if (last_hs_s) begin
                    count_d = {CNT_W{1'b0}};
                    if (enable_in) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hs_s) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            count_q       <= {CNT_W{1'b0}};
            bpm_active_q  <= BPM_DEFAULT;
            bpm_pending_q <= BPM_DEFAULT;
            sel_q         <= SEL_BYPASS;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            bpm_active_q  <= bpm_active_d;
            bpm_pending_q <= bpm_pending_d;
            sel_q         <= sel_d;
        end
    end

    pixel_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load_s),
        .data_in   (src_pix_s),
        .out_ready (output_ready),
        .data_out  (pix_out),
        .valid_out (valid_out),
        .free      (free_s)
    );

endmodule

// File: tb/tb_pixel_filter_scheduler.sv
// Scoreboard bench for pixel_filter_scheduler with a 16-pixel frame.
module tb_pixel_filter_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bpm_in;
    logic       bpm_valid;
    logic       enable_in;
    logic [7:0] pix_in;
    logic       valid_in;
    logic       in_ready;
    logic [7:0] BPM_estimate;
    logic       filter_enable;
    logic       filt_ready;
    logic [7:0] pix_thresh;
    logic       valid_thresh;
    logic [7:0] pix_bright;
    logic       valid_bright;
    logic [7:0] pix_out;
    logic       valid_out;
    logic       output_ready;
    logic [1:0] sel;
    logic       frame_start;
    logic       frame_done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         out_cnt = 0;
    int         fs_cnt = 0;
    int         loads = 0;
    bit         stalled_prev = 1'b0;
    logic [7:0] held_pix;
    logic [7:0] mon_exp;

    pixel_filter_scheduler #(
        .FRAME_PIXELS (16),
        .CNT_W        (5),
        .BRIGHT_BPM   (120),
        .THRESH_BPM   (80),
        .DEFAULT_BPM  (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bpm_in        (bpm_in),
        .bpm_valid     (bpm_valid),
        .enable_in     (enable_in),
        .pix_in        (pix_in),
        .valid_in      (valid_in),
        .in_ready      (in_ready),
        .BPM_estimate  (BPM_estimate),
        .filter_enable (filter_enable),
        .filt_ready    (filt_ready),
        .pix_thresh    (pix_thresh),
        .valid_thresh  (valid_thresh),
        .pix_bright    (pix_bright),
        .valid_bright  (valid_bright),
        .pix_out       (pix_out),
        .valid_out     (valid_out),
        .output_ready  (output_ready),
        .sel           (sel),
        .frame_start   (frame_start),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Each source carries a distinct encoding of the same base value so a
    // wrong source selection shows up as a data error.
    function automatic logic [7:0] src_val(input logic [7:0] v, input int s);
        if (s == 1) return v ^ 8'h55;
        if (s == 2) return v ^ 8'hAA;
        return v;
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                out_cnt      = 0;
                exp_q.delete();
                stalled_prev = 1'b0;
            end else begin
                if (frame_start) fs_cnt++;
                if (stalled_prev) begin
                    chk("stall_hold_valid", valid_out, 1);
                    chk("stall_hold_pix", pix_out, held_pix);
                end
                if (valid_out && output_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel actual=%0d required=none", pix_out);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("pix_out", pix_out, mon_exp);
                    end
                    chk("frame_done", frame_done, (out_cnt == 15) ? 1 : 0);
                    out_cnt = (out_cnt + 1) % 16;
                end else if (frame_done) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done_no_hs actual=1 required=0");
                end
                if (valid_out && !output_ready) begin
                    chk("stall_filt_ready", filt_ready, 0);
                    chk("stall_in_ready", in_ready, 0);
                    held_pix     = pix_out;
                    stalled_prev = 1'b1;
                end else begin
                    stalled_prev = 1'b0;
                end
            end
        end
    end

    // Drive n pixels on all three sources; push the expected-source value
    // whenever the matching ready accepts it.
    task automatic send_frame(input int n, input int base, input int step,
                              input int strobe_at, input logic [7:0] strobe_val,
                              input int drop_at, input int stall_at,
                              input int exp_sel, input int exp_bpm);
        int acc = 0;
        int cyc = 0;
        int stall_left = 0;
        bit strobed = 1'b0;
        bit stalled = 1'b0;
        bit first_pending = 1'b0;
        logic [7:0] first_exp = 8'd0;
        logic [7:0] v;
        logic rdy;
        while (acc < n && cyc < 300) begin
            @(negedge clk);
            if (first_pending) begin
                chk("latency_valid_out", valid_out, 1);
                chk("latency_pix_out", pix_out, first_exp);
                first_pending = 1'b0;
            end
            v            = 8'(base + step * acc);
            pix_in       = v;
            pix_thresh   = src_val(v, 1);
            pix_bright   = src_val(v, 2);
            valid_in     = 1'b1;
            valid_thresh = 1'b1;
            valid_bright = 1'b1;
            bpm_valid    = 1'b0;
            if (acc == strobe_at && !strobed) begin
                bpm_in    = strobe_val;
                bpm_valid = 1'b1;
                strobed   = 1'b1;
            end
            if (acc == drop_at) enable_in = 1'b0;
            if (acc == stall_at && !stalled) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            output_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            rdy = (exp_sel == 0) ? in_ready : filt_ready;
            if (rdy) begin
                exp_q.push_back(src_val(v, exp_sel));
                if (acc == 0) begin
                    first_pending = 1'b1;
                    first_exp     = src_val(v, exp_sel);
                end
                acc++;
            end
            cyc++;
        end
        chk("frame_accept_budget", acc, n);
        chk("sel_frozen_in_frame", sel, exp_sel);
        chk("bpm_frozen_in_frame", BPM_estimate, exp_bpm);
        @(negedge clk);
        valid_in     = 1'b0;
        valid_thresh = 1'b0;
        valid_bright = 1'b0;
        bpm_valid    = 1'b0;
        output_ready = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_load(input int target, input int exp_bpm, input int exp_sel);
        for (int i = 0; i < 60 && fs_cnt < target; i++) @(negedge clk);
        chk("frame_start_count", fs_cnt, target);
        #1;
        chk("sel_after_load", sel, exp_sel);
        chk("bpm_after_load", BPM_estimate, exp_bpm);
        chk("filter_enable_after_load", filter_enable, (exp_sel != 0) ? 1 : 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_sel", sel, 0);
        chk("rst_bpm", BPM_estimate, 100);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_filter_enable", filter_enable, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_filt_ready", filt_ready, 0);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        reset        = 1'b0;
        bpm_in       = 8'd0;
        bpm_valid    = 1'b0;
        enable_in    = 1'b0;
        pix_in       = 8'd0;
        valid_in     = 1'b0;
        pix_thresh   = 8'd0;
        valid_thresh = 1'b0;
        pix_bright   = 8'd0;
        valid_bright = 1'b0;
        output_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Strobe in IDLE only updates pending.
        @(negedge clk);
        bpm_in    = 8'd200;
        bpm_valid = 1'b1;
        @(negedge clk);
        bpm_valid = 1'b0;
        #1;
        chk("idle_bpm_unchanged", BPM_estimate, 100);
        chk("idle_sel_unchanged", sel, 0);
        chk("idle_no_frame_start", frame_start, 0);
        enable_in = 1'b1;

        // Frame 1: brightness, strobe 90 mid-frame.
        loads++;
        wait_load(loads, 200, 2);
        send_frame(16, 10, 3, 8, 8'd90, -1, -1, 2, 200);
        wait_drain();

        // Frame 2: threshold, downstream stall, strobe 56.
        loads++;
        wait_load(loads, 90, 1);
        send_frame(16, 40, 7, 4, 8'd56, -1, 6, 1, 90);
        wait_drain();

        // Frame 3: bypass with descending pixels, strobe 130.
        loads++;
        wait_load(loads, 56, 0);
        send_frame(16, 255, -25, 3, 8'd130, -1, -1, 0, 56);
        wait_drain();

        // Frame 4: brightness, enable dropped at pixel 5.
        loads++;
        wait_load(loads, 130, 2);
        send_frame(16, 100, 11, -1, 8'd0, 5, -1, 2, 130);
        wait_drain();
        @(negedge clk);
        #1;
        chk("idle_filter_enable", filter_enable, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_filt_ready", filt_ready, 0);
        repeat (5) @(negedge clk);
        chk("idle_no_reload", fs_cnt, loads);

        // Frame 5: partial, then reset mid-frame.
        enable_in = 1'b1;
        loads++;
        wait_load(loads, 130, 2);
        send_frame(5, 1, 1, -1, 8'd0, -1, -1, 2, 130);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        enable_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("post_reset_no_load", fs_cnt, loads);
        chk("post_reset_filter_enable", filter_enable, 0);
        chk("post_reset_in_ready", in_ready, 0);

        // Frame 6: restart needs a fresh LOAD with the default BPM.
        enable_in = 1'b1;
        loads++;
        wait_load(loads, 100, 1);
        send_frame(16, 7, 5, -1, 8'd0, -1, -1, 1, 100);
        wait_drain();
        enable_in = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
